irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt source side of the CP0 interrupt handshake.
- Collects NUM_SRC peripheral interrupt lines and latches rising edges as pending bits.
- Masks and prioritises the pending bits, then drives the single interrupt request line into CP0 `ir_in`.
- Holds the request until the CPU acknowledges the interrupt entry. It then blocks new requests until ERET signals end-of-interrupt.
- Software reads and writes its registers through a small word-addressed register port driven from the MEM stage.

Parameters:
- NUM_SRC, 8, number of interrupt source lines (2..16).
- VEC_W, 4, vector width; must satisfy 2^VEC_W >= NUM_SRC.

Ports:
- clk  input  1  main clock
- rst  input  1  asynchronous reset, active-high
- src  input  NUM_SRC  asynchronous peripheral interrupt lines, rising-edge significant
- ack  input  1  CPU took the interrupt (CP0 `jump_en` caused by an interrupt)
- eoi  input  1  end of interrupt (CP0 ERET executed)
- reg_addr  input  2  register select
- reg_we  input  1  register write strobe
- reg_wdata  input  32  register write data
- reg_rdata  output  32  register read data (combinational)
- ir_out  output  1  interrupt request to CP0 `ir_in`
- vector  output  VEC_W  index of the requested / in-service source

Behaviour:
- Reset (asynchronous, immediate):
  - mask, pending and in-service registers = 0.
  - All synchronizer and edge flops = 0.
  - state = IDLE; ir_out = 0; vector = 0.
  - A src line held high through reset yields exactly one edge after reset release.
- Input path:
  - Each src bit passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - edge = s2 & ~s3.
  - pending[i] is set on the clock where edge[i] = 1.
  - Latency: src first sampled high at edge k → pending set at edge k+2 → state REQ and ir_out = 1 after edge k+3.
- Qualification and priority:
  - req_vec = pending & mask.
  - Priority is fixed: the lowest index wins.
- State machine (ir_out = (state == REQ), registered):
  - IDLE → REQ when req_vec != 0; vector <= encoded winner.
  - REQ:
    - Each cycle, vector <= current winner, so a newly arrived higher-priority source replaces the requested vector before ack.
    - If req_vec becomes 0 (mask or clear withdrew it) → IDLE; ir_out drops and vector holds its last value.
    - On ack: pending[vector] cleared, in_service <= vector, next state SERVICE.
  - SERVICE:
    - ir_out = 0; new pending bits accumulate silently.
    - On eoi → IDLE. If req_vec != 0, the next request rises one cycle later.
- Ignored inputs: ack outside REQ and eoi outside SERVICE are ignored.
- Simultaneous set/clear: if an edge and a clear (ack or write-1-to-clear) hit the same pending bit on the same cycle, set wins.
- Registers (write on reg_we at the clock edge; read is combinational):
  - addr 0 MASK: RW, bits [NUM_SRC-1:0]; upper bits read 0.
  - addr 1 PENDING: read returns pending. Write-1-to-clear.
  - addr 2 STATUS: read-only. [1:0] = state (IDLE = 0, REQ = 1, SERVICE = 2); [8 +: VEC_W] = in_service. Writes are ignored.
  - addr 3 SWTRIG: write-1-to-set pending (software interrupt); reads 0.
- Mid-operation reset: reset in any state returns to IDLE within the same cycle and drops ir_out immediately.
- Undefined state code: recovers to IDLE on the next clock.

Test Plan:
- Basic request: MASK = 0x01; pulse src[0] for 1 cycle → ir_out rises after the 4th edge with vector = 0. ack for 1 cycle → ir_out = 0, PENDING = 0x00, STATUS[1:0] = 2, STATUS[11:8] = 0. eoi → STATUS[1:0] = 0.
- Priority and preemption: MASK = 0xFF; edge on src[5], then edge on src[2] while in REQ before ack → vector changes 5 → 2. After ack: PENDING = 0x20. After eoi: ir_out re-rises with vector = 5.
- Masking and withdrawal: MASK = 0x00; edge on src[3] → PENDING = 0x08 and ir_out stays 0. Write MASK = 0x08 → ir_out = 1. Write MASK = 0x00 while in REQ → ir_out = 0 next cycle, state IDLE.
- Software registers: write SWTRIG = 0x40 with MASK = 0x40 → ir_out = 1, vector = 6. Write PENDING = 0x40 → ir_out = 0. Assert a src[1] edge on the same cycle as a write PENDING = 0x02 → pending[1] remains 1.
- Spurious handshakes: ack in IDLE and eoi in REQ → no state change, PENDING unchanged.
- Reset mid-service: in SERVICE with PENDING = 0x10, assert rst asynchronously between clock edges → ir_out = 0, MASK = 0, PENDING = 0, STATUS = 0 before the next clock edge.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt source for the CP0 handshake: synchronises and edge-detects the
// peripheral lines, masks and prioritises them, and drives ir_in until ack/eoi.
module irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               ack,
  input  logic               eoi,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               ir_out,
  output logic [VEC_W-1:0]   vector
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] mask_q, mask_d, pend_q, pend_d;
  logic [NUM_SRC-1:0] req_vec, edge_det, set_v, clr_v;
  logic [VEC_W-1:0]   vec_q, vec_d, insvc_q, insvc_d, win;
  logic               unused_wdata;

  assign edge_det     = s2_q & ~s3_q;
  assign req_vec      = pend_q & mask_q;
  assign unused_wdata = ^reg_wdata[31:NUM_SRC];

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req_vec[i]) win = VEC_W'(i);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    insvc_d = insvc_q;
    mask_d  = mask_q;
    set_v   = edge_det;
    clr_v   = '0;
    if (reg_we) begin
      case (reg_addr)
        2'd0:    mask_d = reg_wdata[NUM_SRC-1:0];
        2'd1:    clr_v  = reg_wdata[NUM_SRC-1:0];
        2'd3:    set_v  = set_v | reg_wdata[NUM_SRC-1:0];
        default: ;
      endcase
    end
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d = REQ;
          vec_d   = win;
        end
      end
      REQ: begin
        // The CPU has already committed to the entry once ack arrives, so it
        // outranks a simultaneous withdrawal.
        if (ack) begin
          clr_v   = clr_v | ({{(NUM_SRC-1){1'b0}}, 1'b1} << vec_q);
          insvc_d = vec_q;
          state_d = SERVICE;
        end else if (req_vec == '0) begin
          state_d = IDLE;
        end else begin
          vec_d = win;
        end
      end
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Set after clear so a coincident edge or SWTRIG wins.
    pend_d = (pend_q & ~clr_v) | set_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      insvc_q <= '0;
      vec_q   <= '0;
      state_q <= IDLE;
    end else begin
      s1_q    <= src;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
      vec_q   <= vec_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata[NUM_SRC-1:0] = mask_q;
      2'd1: reg_rdata[NUM_SRC-1:0] = pend_q;
      2'd2: begin
        reg_rdata[1:0]       = state_q;
        reg_rdata[8 +: VEC_W] = insvc_q;
      end
      default: ;
    endcase
  end

  assign ir_out = (state_q == REQ);
  assign vector = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed vector bench for irq_controller: a table of per-cycle stimulus with
// expected outputs, plus hand sequences for reset and mid-service reset.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        ack, eoi;
  logic [1:0]  reg_addr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        ir_out;
  logic [3:0]  vector;

  int n_vec = 0;
  int n_err = 0;

  irq_controller #(.NUM_SRC(8), .VEC_W(4)) dut (
    .clk(clk), .rst(rst), .src(src), .ack(ack), .eoi(eoi),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .ir_out(ir_out), .vector(vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  src;
    logic        ack;
    logic        eoi;
    logic [1:0]  raddr;
    logic        exp_ir;
    logic [3:0]  exp_vec;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[40];

  function automatic vec_t mk(logic we, logic [1:0] wa, logic [31:0] wd, logic [7:0] s,
                              logic a, logic e, logic [1:0] ra, logic ir, logic [3:0] v,
                              logic [31:0] rd);
    vec_t r;
    r.we = we; r.waddr = wa; r.wdata = wd; r.src = s; r.ack = a; r.eoi = e;
    r.raddr = ra; r.exp_ir = ir; r.exp_vec = v; r.exp_rd = rd;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, release strobes after the edge, then read.
  task automatic cycle(logic we, logic [1:0] wa, logic [31:0] wd, logic a, logic e,
                       logic [1:0] ra);
    @(negedge clk);
    reg_we = we; reg_addr = wa; reg_wdata = wd; ack = a; eoi = e;
    @(posedge clk);
    #1;
    reg_we = 1'b0; ack = 1'b0; eoi = 1'b0; reg_addr = ra;
    #1;
  endtask

  initial begin
    //               we wa wdata        src    ack eoi ra ir vec rdata
    // basic request on src[0]
    tbl[0]  = mk(1, 0, 32'h01,        8'h00, 0, 0, 0, 0, 0, 32'h01);
    tbl[1]  = mk(0, 0, 0,             8'h01, 0, 0, 1, 0, 0, 32'h00);
    tbl[2]  = mk(0, 0, 0,             8'h00, 0, 0, 1, 0, 0, 32'h00);
    tbl[3]  = mk(0, 0, 0,             8'h00, 0, 0, 1, 0, 0, 32'h01);
    tbl[4]  = mk(0, 0, 0,             8'h00, 0, 0, 2, 1, 0, 32'h001);
    tbl[5]  = mk(0, 0, 0,             8'h00, 1, 0, 1, 0, 0, 32'h00);
    tbl[6]  = mk(0, 0, 0,             8'h00, 0, 0, 2, 0, 0, 32'h002);
    tbl[7]  = mk(0, 0, 0,             8'h00, 0, 1, 2, 0, 0, 32'h000);
    // priority: src[5] then src[2] preempts before ack
    tbl[8]  = mk(1, 0, 32'hFF,        8'h20, 0, 0, 0, 0, 0, 32'hFF);
    tbl[9]  = mk(0, 0, 0,             8'h20, 0, 0, 1, 0, 0, 32'h00);
    tbl[10] = mk(0, 0, 0,             8'h24, 0, 0, 1, 0, 0, 32'h20);
    tbl[11] = mk(0, 0, 0,             8'h24, 0, 0, 1, 1, 5, 32'h20);
    tbl[12] = mk(0, 0, 0,             8'h24, 0, 0, 1, 1, 5, 32'h24);
    tbl[13] = mk(0, 0, 0,             8'h24, 0, 0, 1, 1, 2, 32'h24);
    tbl[14] = mk(0, 0, 0,             8'h24, 1, 0, 1, 0, 2, 32'h20);
    tbl[15] = mk(0, 0, 0,             8'h24, 0, 0, 2, 0, 2, 32'h202);
    tbl[16] = mk(0, 0, 0,             8'h24, 0, 1, 2, 0, 2, 32'h200);
    tbl[17] = mk(0, 0, 0,             8'h24, 0, 0, 2, 1, 5, 32'h201);
    tbl[18] = mk(0, 0, 0,             8'h24, 1, 0, 1, 0, 5, 32'h00);
    tbl[19] = mk(0, 0, 0,             8'h24, 0, 1, 2, 0, 5, 32'h500);
    // spurious ack while idle
    tbl[20] = mk(0, 0, 0,             8'h00, 1, 0, 2, 0, 5, 32'h500);
    // masking, spurious eoi in REQ, withdrawal
    tbl[21] = mk(1, 0, 32'h00,        8'h08, 0, 0, 0, 0, 5, 32'h00);
    tbl[22] = mk(0, 0, 0,             8'h08, 0, 0, 1, 0, 5, 32'h00);
    tbl[23] = mk(0, 0, 0,             8'h08, 0, 0, 1, 0, 5, 32'h08);
    tbl[24] = mk(1, 0, 32'h08,        8'h08, 0, 0, 0, 0, 5, 32'h08);
    tbl[25] = mk(0, 0, 0,             8'h08, 0, 0, 2, 1, 3, 32'h501);
    tbl[26] = mk(0, 0, 0,             8'h08, 0, 1, 1, 1, 3, 32'h08);
    tbl[27] = mk(1, 0, 32'h00,        8'h08, 0, 0, 0, 1, 3, 32'h00);
    tbl[28] = mk(0, 0, 0,             8'h08, 0, 0, 2, 0, 3, 32'h500);
    tbl[29] = mk(1, 1, 32'h08,        8'h00, 0, 0, 1, 0, 3, 32'h00);
    // software trigger and write-1-to-clear
    tbl[30] = mk(1, 0, 32'h40,        8'h00, 0, 0, 0, 0, 3, 32'h40);
    tbl[31] = mk(1, 3, 32'h40,        8'h00, 0, 0, 1, 0, 3, 32'h40);
    tbl[32] = mk(0, 0, 0,             8'h00, 0, 0, 3, 1, 6, 32'h00);
    tbl[33] = mk(1, 1, 32'h40,        8'h00, 0, 0, 1, 1, 6, 32'h00);
    tbl[34] = mk(0, 0, 0,             8'h00, 0, 0, 2, 0, 6, 32'h500);
    // edge on src[1] coincides with W1C of the same bit: set wins
    tbl[35] = mk(0, 0, 0,             8'h02, 0, 0, 1, 0, 6, 32'h00);
    tbl[36] = mk(0, 0, 0,             8'h02, 0, 0, 1, 0, 6, 32'h00);
    tbl[37] = mk(1, 1, 32'h02,        8'h02, 0, 0, 1, 0, 6, 32'h02);
    tbl[38] = mk(1, 1, 32'h02,        8'h02, 0, 0, 1, 0, 6, 32'h00);
    // STATUS is read-only
    tbl[39] = mk(1, 2, 32'hFFFFFFFF,  8'h00, 0, 0, 2, 0, 6, 32'h500);

    rst = 1'b1; src = 8'hFF; ack = 0; eoi = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0;
    #12;
    chk("reset ir_out", 32'(ir_out), 32'h0);
    chk("reset vector", 32'(vector), 32'h0);
    reg_addr = 2'd1; #1 chk("reset pending", reg_rdata, 32'h0);
    reg_addr = 2'd2; #1 chk("reset status", reg_rdata, 32'h0);
    src = 8'h00;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      src = tbl[i].src;
      cycle(tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].ack, tbl[i].eoi, tbl[i].raddr);
      chk($sformatf("v%0d ir_out", i), 32'(ir_out), 32'(tbl[i].exp_ir));
      chk($sformatf("v%0d vector", i), 32'(vector), 32'(tbl[i].exp_vec));
      chk($sformatf("v%0d rdata", i), reg_rdata, tbl[i].exp_rd);
    end

    // Reset mid-service with a pending bit accumulated during service.
    cycle(1, 0, 32'h10, 0, 0, 1);
    src = 8'h10;
    cycle(0, 0, 0, 0, 0, 1);
    src = 8'h00;
    begin
      int n = 0;
      while (!ir_out && n < 10) begin
        cycle(0, 0, 0, 0, 0, 1);
        n++;
      end
    end
    chk("mid ir_out raised", 32'(ir_out), 32'h1);
    chk("mid vector", 32'(vector), 32'h4);
    cycle(0, 0, 0, 1, 0, 2);
    chk("mid status service", reg_rdata, 32'h402);
    cycle(1, 3, 32'h10, 0, 0, 1);
    chk("mid pending in service", reg_rdata, 32'h10);
    chk("mid ir_out quiet", 32'(ir_out), 32'h0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst ir_out", 32'(ir_out), 32'h0);
    chk("rst vector", 32'(vector), 32'h0);
    reg_addr = 2'd0; #0.1 chk("rst mask", reg_rdata, 32'h0);
    reg_addr = 2'd1; #0.1 chk("rst pending", reg_rdata, 32'h0);
    reg_addr = 2'd2; #0.1 chk("rst status", reg_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
